cipher_stream_decrypt: RTL and testbench

- Receive-side counterpart of the team's byte-stream cipher: takes ciphertext bytes and returns plaintext bytes.
- Regenerates the encryptor's keystream with an identical 16-bit Galois LFSR seeded from the shared key, then XORs it onto each ciphertext byte.
- Sits between the ciphertext input pins and the plaintext output register of the top-level, with valid/ready handshakes on both sides.

---
 rtl/cipher_stream_decrypt.sv | 147 ++++++++++++++
 tb/tb_cipher_stream_decrypt.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cipher_stream_decrypt.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : cipher_stream_decrypt
// Brief    : Byte-stream decryptor. Rebuilds the encryptor's keystream with a
//            16-bit Galois LFSR seeded from the shared key and XORs 8 keystream
//            bits onto each ciphertext byte. Valid/ready on both sides; at most
//            one byte is in flight.
// Options  : CIPHER_CHAIN_EN - ciphertext-feedback chaining (XOR in the
//            previous ciphertext byte as well).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module cipher_stream_decrypt #(
  parameter int               KEY_W     = 16,
  parameter logic [KEY_W-1:0] POLY      = 16'hB400,
  parameter logic [KEY_W-1:0] ZERO_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy,
  output logic             keyed
);

  typedef enum logic [1:0] {
    S_NOKEY = 2'd0,
    S_IDLE  = 2'd1,
    S_STEP  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t           r_state;
  logic [KEY_W-1:0] r_lfsr;
  logic [2:0]       r_cnt;
  logic [7:0]       r_ks;
  logic [7:0]       r_ct;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [7:0]       r_out_data;
  logic             r_busy;
  logic             r_keyed;
`ifdef CIPHER_CHAIN_EN
  logic [7:0]       r_prev_ct;
`endif

  logic [KEY_W-1:0] w_lfsr_next;
  logic [KEY_W-1:0] w_seed;
  logic [7:0]       w_ks_final;
  logic [7:0]       w_plain;

  // Next LFSR value, substituted seed for an all-zero key, and the plaintext
  // formed on the last step (bit 7 of the keystream is the bit shifted out now).
  always_comb begin
    w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ POLY) : (r_lfsr >> 1);
    w_seed      = (key_in == '0) ? ZERO_SEED : key_in;
    w_ks_final  = {r_lfsr[0], r_ks[6:0]};
`ifdef CIPHER_CHAIN_EN
    w_plain     = r_ct ^ w_ks_final ^ r_prev_ct;
`else
    w_plain     = r_ct ^ w_ks_final;
`endif
  end

  // Control FSM with registered outputs; key_load overrides every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_NOKEY;
      r_lfsr      <= ZERO_SEED;
      r_cnt       <= 3'd0;
      r_ks        <= 8'd0;
      r_ct        <= 8'd0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'd0;
      r_busy      <= 1'b0;
      r_keyed     <= 1'b0;
`ifdef CIPHER_CHAIN_EN
      r_prev_ct   <= 8'd0;
`endif
    end else if (key_load) begin
      // Fresh key: drop any byte in flight or held, restart the keystream.
      r_lfsr      <= w_seed;
      r_cnt       <= 3'd0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_keyed     <= 1'b1;
      r_state     <= S_IDLE;
`ifdef CIPHER_CHAIN_EN
      r_prev_ct   <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_NOKEY: begin
          r_in_ready <= 1'b0;
        end
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_ct       <= in_data;
            r_cnt      <= 3'd0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_STEP;
          end
        end
        S_STEP: begin
          r_ks[r_cnt] <= r_lfsr[0];
          r_lfsr      <= w_lfsr_next;
          r_cnt       <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_out_data  <= w_plain;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
`ifdef CIPHER_CHAIN_EN
            r_prev_ct   <= r_ct;
`endif
          end
        end
        default: begin
          r_state <= S_NOKEY;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign keyed     = r_keyed;

endmodule
`default_nettype wire

// File: tb/tb_cipher_stream_decrypt.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_cipher_stream_decrypt
// Brief    : Directed self-checking bench for cipher_stream_decrypt. Honours
//            CIPHER_CHAIN_EN for the chained expectations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_cipher_stream_decrypt;

  logic        clk;
  logic        rst;
  logic        key_load;
  logic [15:0] key_in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic        keyed;

  int n_checks;
  int n_pass;

  cipher_stream_decrypt dut (
    .clk       (clk),
    .rst       (rst),
    .key_load  (key_load),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .keyed     (keyed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Pulse key_load for exactly one rising edge.
  task automatic load_key(input logic [15:0] k);
    @(negedge clk);
    key_in   = k;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  // Offer a byte and hold in_valid until it is accepted (bounded wait).
  task automatic send_ct(input logic [7:0] ct);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = ct;
    w = 0;
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the negedge after the accept edge; returns cycles (accept cycle
  // counted as 1) until out_valid is seen, and whether busy was high in STEP.
  task automatic wait_out(output int lat, output logic saw_busy);
    lat      = 1;
    saw_busy = busy;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("out_timeout", 32'd0, 32'd1);
  endtask

  // One output handshake, then confirm return to IDLE.
  task automatic take_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int          lat;
    logic        sb;
    logic        bad;
    logic [7:0]  exp2;
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    key_load  = 1'b0;
    key_in    = 16'h0000;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // Reset state.
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_keyed", 32'(keyed), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // No key: input is ignored indefinitely.
    in_valid = 1'b1;
    in_data  = 8'h5A;
    bad      = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (in_ready || out_valid || keyed) bad = 1'b1;
    end
    in_valid = 1'b0;
    chk("nokey_ignored", 32'(bad), 32'd0);

    // Key ACE1: ks low byte E1, next E1-step LFSR C2C4.
    load_key(16'hACE1);
    chk("keyed_set", 32'(keyed), 32'd1);
    chk("idle_ready", 32'(in_ready), 32'd1);
    send_ct(8'h41);
    wait_out(lat, sb);
    chk("latency", 32'(lat), 32'd9);
    chk("busy_in_step", 32'(sb), 32'd1);
    chk("pt0_ace1", 32'(out_data), 32'hA0);
    take_out("b0");

    // Second byte held for 20 cycles in HOLD.
`ifdef CIPHER_CHAIN_EN
    exp2 = 8'h85;
`else
    exp2 = 8'hC4;
`endif
    send_ct(8'h00);
    wait_out(lat, sb);
    chk("pt1_ace1", 32'(out_data), 32'(exp2));
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || out_data !== exp2 || in_ready || busy) bad = 1'b1;
    end
    chk("hold_stable", 32'(bad), 32'd0);
    take_out("b1");

    // All-zero key behaves like ACE1.
    load_key(16'h0000);
    send_ct(8'hE1);
    wait_out(lat, sb);
    chk("pt_zero_key", 32'(out_data), 32'h00);
    take_out("b2");

    // key_load in the 4th STEP cycle aborts the byte.
    load_key(16'hACE1);
    send_ct(8'h55);
    repeat (3) @(negedge clk);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    key_in   = 16'h1234;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    bad = 1'b0;
    repeat (15) begin
      if (out_valid || busy) bad = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_out", 32'(bad), 32'd0);
    chk("abort_idle", 32'(in_ready), 32'd1);
    send_ct(8'h34);
    wait_out(lat, sb);
    chk("pt_1234", 32'(out_data), 32'h00);
    take_out("b3");

    // out_ready with nothing valid is ignored.
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    chk("stray_ready", 32'(out_valid), 32'd0);
    chk("stray_idle", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
